// File: rtl/svc_soc_io_uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// STATUS/RXDATA bit positions and the receive FSM state type.
package svc_soc_io_uart_rx_pkg;

    localparam logic [31:0] RXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVR       = 2;
    localparam int ST_FERR      = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int RX_VALID_BIT = 31;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    // FIFO count squeezed into the 4-bit STATUS field; deeper FIFOs saturate.
    function automatic logic [3:0] sat_nibble(input logic [31:0] v);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/svc_uart_rx_core.sv
// 8N1 receive engine: input synchronizer, bit timer and framing FSM.
// Emits one-cycle byte_valid / ferr_pulse strobes; byte_data holds the
// assembled byte while byte_valid is high.
module svc_uart_rx_core
    import svc_soc_io_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           uart_rx,
    output logic           byte_valid,
    output logic [7:0]     byte_data,
    output logic           ferr_pulse,
    output uart_rx_state_t state
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);

    logic [1:0]     sync;
    logic           rx_s;
    uart_rx_state_t state_nx;
    logic [TW-1:0]  timer, timer_nx;
    logic [2:0]     bit_idx, bit_nx;
    logic [7:0]     shift, shift_nx;

    // Two-flop synchronizer, preset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], uart_rx};
    end

    assign rx_s      = sync[1];
    assign byte_data = shift;

    // FSM, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
        end
    end

    // Next-state logic: mid-bit start check, LSB-first data, stop-bit framing.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        bit_nx     = bit_idx;
        shift_nx   = shift;
        byte_valid = 1'b0;
        ferr_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    timer_nx = '0;
                end
            end
            START: begin
                if (timer == T_HALF) begin
                    timer_nx = '0;
                    if (!rx_s) begin
                        state_nx = DATA;
                        bit_nx   = 3'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == T_LAST) begin
                    timer_nx = '0;
                    shift_nx = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) state_nx = STOP;
                    else                 bit_nx   = bit_idx + 3'd1;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            STOP: begin
                if (timer == T_LAST) begin
                    timer_nx = '0;
                    if (rx_s) begin
                        byte_valid = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        ferr_pulse = 1'b1;
                        state_nx   = WAIT_IDLE;
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must return high before a new frame.
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/svc_soc_io_uart_rx.sv
// Memory-mapped UART receiver: RX core feeding a byte FIFO that software
// polls through RXDATA (pop on read) and STATUS (W1C error flags).
module svc_soc_io_uart_rx
    import svc_soc_io_uart_rx_pkg::*;
#(
    parameter int          CLOCK_FREQ = 25_000_000,
    parameter int          BAUD_RATE  = 115_200,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    input  logic        uart_rx,
    output logic        rx_irq
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic           byte_valid, ferr_pulse;
    logic [7:0]     byte_data;
    uart_rx_state_t core_state;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  head, tail;
    logic [CW-1:0]  count;
    logic           fifo_empty, fifo_full;
    logic           rd_rxdata, rd_status, wr_status;
    logic           push, pop, ovr_set;
    logic           ovr, ferr;
    logic [31:0]    status_word;
    logic           unused_ok;

    svc_uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .ferr_pulse(ferr_pulse),
        .state     (core_state)
    );

    assign rd_rxdata  = io_ren && (io_raddr == BASE_ADDR + RXDATA_OFS);
    assign rd_status  = io_ren && (io_raddr == BASE_ADDR + STATUS_OFS);
    assign wr_status  = io_wen && (io_waddr == BASE_ADDR + STATUS_OFS) && io_wstrb[0];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts.
    assign pop        = rd_rxdata && !fifo_empty;
    assign push       = byte_valid && (!fifo_full || pop);
    assign ovr_set    = byte_valid && fifo_full && !pop;
    assign rx_irq     = !fifo_empty;
    assign unused_ok  = ^{io_wdata[31:4], io_wdata[1:0], io_wstrb[3:1], core_state};

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= byte_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a same-cycle set overrides the W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= (ovr  && !(wr_status && io_wdata[ST_OVR]))  || ovr_set;
            ferr <= (ferr && !(wr_status && io_wdata[ST_FERR])) || ferr_pulse;
        end
    end

    // STATUS register image.
    always_comb begin
        status_word                          = '0;
        status_word[ST_NOT_EMPTY]            = !fifo_empty;
        status_word[ST_FULL]                 = fifo_full;
        status_word[ST_OVR]                  = ovr;
        status_word[ST_FERR]                 = ferr;
        status_word[ST_COUNT_LSB +: 4]       = sat_nibble(32'(count));
    end

    // Registered read port; zero whenever nothing mapped is being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= '0;
        end else if (rd_rxdata) begin
            io_rdata <= fifo_empty ? 32'h0 : {1'b1, 23'b0, mem[head]};
        end else if (rd_status) begin
            io_rdata <= status_word;
        end else begin
            io_rdata <= '0;
        end
    end

endmodule
